// File: rtl/btb_pkg.sv
// Shared BTB types and geometry for the update controller.
// Coalescing of repeated pc updates is enabled by defining BTB_UPD_COALESCE_EN.
package btb_pkg;

   localparam int unsigned BTB_IDX_W = 8;
   localparam int unsigned BTB_TAG_W = 9;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
   } btb_upd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } btb_fsm_e;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// EX resolve inputs and BTB write/invalidate port of the update controller.
interface btb_update_ctrl_if #(parameter int unsigned IDX_W = 8);

   logic             ex_valid_i;
   logic             ex_taken_i;
   logic [31:0]      ex_pc_i;
   logic [31:0]      ex_target_i;
   logic             btb_we_o;
   logic [31:0]      btb_pc_o;
   logic [31:0]      btb_addr_o;
   logic             btb_inv_o;
   logic [IDX_W-1:0] btb_inv_idx_o;

   modport master (
      output ex_valid_i, ex_taken_i, ex_pc_i, ex_target_i,
      input  btb_we_o, btb_pc_o, btb_addr_o, btb_inv_o, btb_inv_idx_o
   );

   modport slave (
      input  ex_valid_i, ex_taken_i, ex_pc_i, ex_target_i,
      output btb_we_o, btb_pc_o, btb_addr_o, btb_inv_o, btb_inv_idx_o
   );

endinterface

// File: rtl/btb_upd_fifo.sv
// Circular update buffer with tail peek (for coalescing) and synchronous clear.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter bit          COAL_EN = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   coal_i,
   input  btb_upd_t               din_i,
   input  logic [31:0]            cmp_pc_i,
   output btb_upd_t               head_o,
   output logic                   tail_match_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   btb_upd_t   mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q, tail_idx;
   logic [CNT_W-1:0] cnt_q;

   assign tail_idx     = wr_q - PTR_W'(1);
   assign head_o       = mem_q[rd_q];
   assign full_o       = (cnt_q == CNT_W'(DEPTH));
   assign empty_o      = (cnt_q == '0);
   assign count_o      = cnt_q;
   assign tail_match_o = COAL_EN && !empty_o && (mem_q[tail_idx].pc == cmp_pc_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PTR_W'(1);
         if (pop_i)  rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   // Payload storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wr_q] <= din_i;
      if (coal_i && !clr_i) mem_q[tail_idx].target <= din_i.target;
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sole writer of the BTB: drains buffered taken-branch updates and runs the flush sweep.
// Optional feature: BTB_UPD_COALESCE_EN merges a repeat pc into the newest queued entry.
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned IDX_W  = BTB_IDX_W,
   parameter int unsigned DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush_req_i,
   btb_update_ctrl_if.slave  bus,
   output logic              upd_full_o,
   output logic              flush_busy_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [IDX_W:0] SWEEP_N = {1'b1, {IDX_W{1'b0}}};
`ifdef BTB_UPD_COALESCE_EN
   localparam bit COAL_EN = 1'b1;
`else
   localparam bit COAL_EN = 1'b0;
`endif

   btb_fsm_e          state_q;
   logic              we_q, inv_q, busy_q;
   logic [31:0]       pc_q, addr_q;
   logic [IDX_W-1:0]  inv_idx_q;
   logic [IDX_W:0]    nxt_q;
   logic [DROP_W-1:0] drop_q, drop_d;

   btb_upd_t         in_upd, head, upd_out;
   logic             full, empty, coal_hit;
   logic [CNT_W-1:0] count;
   logic upd_req, idle, flush_go, take, pop_go, bypass;
   logic fifo_push, fifo_pop, fifo_coal, drop;

   assign in_upd = '{pc: bus.ex_pc_i, target: bus.ex_target_i};

   // An empty FIFO (or a coalesce into the only entry being drained) forwards
   // the incoming update straight to the write port so the write lands next cycle.
   always_comb begin
      upd_req   = bus.ex_valid_i & bus.ex_taken_i;
      idle      = (state_q == IDLE);
      flush_go  = idle & rdy & flush_req_i;
      take      = upd_req & idle & ~flush_go & (~full | coal_hit);
      pop_go    = idle & rdy & ~flush_go & (~empty | take);
      bypass    = pop_go & (empty | (coal_hit & (count == CNT_W'(1))));
      fifo_push = take & ~coal_hit & ~bypass;
      fifo_coal = take & coal_hit & ~bypass;
      fifo_pop  = pop_go & ~empty;
      upd_out   = bypass ? in_upd : head;
      drop      = upd_req & ~take;
      drop_d    = (drop && (drop_q != {DROP_W{1'b1}})) ? drop_q + DROP_W'(1) : drop_q;
   end

   btb_upd_fifo #(.DEPTH(DEPTH), .COAL_EN(COAL_EN)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (flush_go),
      .push_i       (fifo_push),
      .pop_i        (fifo_pop),
      .coal_i       (fifo_coal),
      .din_i        (in_upd),
      .cmp_pc_i     (bus.ex_pc_i),
      .head_o       (head),
      .tail_match_o (coal_hit),
      .full_o       (full),
      .empty_o      (empty),
      .count_o      (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         inv_q     <= 1'b0;
         busy_q    <= 1'b0;
         pc_q      <= '0;
         addr_q    <= '0;
         inv_idx_q <= '0;
         nxt_q     <= '0;
         drop_q    <= '0;
      end else begin
         drop_q <= drop_d;
         we_q   <= pop_go;
         inv_q  <= 1'b0;
         if (pop_go) begin
            pc_q   <= upd_out.pc;
            addr_q <= upd_out.target;
         end
         // nxt_q is the next index to invalidate; reaching 2**IDX_W ends the sweep.
         case (state_q)
            IDLE: if (flush_go) begin
               state_q   <= SWEEP;
               busy_q    <= 1'b1;
               inv_q     <= 1'b1;
               inv_idx_q <= '0;
               nxt_q     <= (IDX_W+1)'(1);
            end
            SWEEP: if (rdy) begin
               if (nxt_q == SWEEP_N) begin
                  state_q <= DONE;
               end else begin
                  inv_q     <= 1'b1;
                  inv_idx_q <= nxt_q[IDX_W-1:0];
                  nxt_q     <= nxt_q + (IDX_W+1)'(1);
               end
            end
            DONE: if (rdy) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.btb_we_o      = we_q;
   assign bus.btb_pc_o      = pc_q;
   assign bus.btb_addr_o    = addr_q;
   assign bus.btb_inv_o     = inv_q;
   assign bus.btb_inv_idx_o = inv_idx_q;
   assign upd_full_o        = (count == CNT_W'(DEPTH));
   assign flush_busy_o      = busy_q;
   assign drop_cnt_o        = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios plus random traffic against a queue model.
module tb_btb_update_ctrl;
   import btb_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef BTB_UPD_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rdy, flush_req_i;
   logic        upd_full_o, flush_busy_o;
   logic [15:0] drop_cnt_o;

   btb_update_ctrl_if #(.IDX_W(8)) bus();

   btb_update_ctrl #(.DEPTH(DEPTH), .IDX_W(8), .DROP_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .flush_req_i  (flush_req_i),
      .bus          (bus),
      .upd_full_o   (upd_full_o),
      .flush_busy_o (flush_busy_o),
      .drop_cnt_o   (drop_cnt_o)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Reference model: pending updates in order, sweep phase 0 idle / 1 sweep / 2 done.
   btb_upd_t    mq[$];
   int          m_phase, m_next, m_drop;
   logic        e_we, e_inv;
   logic [31:0] e_pc, e_addr;
   logic [7:0]  e_idx;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got=%0h exp=%0h t=%0t", phase, tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_phase = 0; m_next = 0; m_drop = 0;
      e_we = 1'b0; e_inv = 1'b0; e_pc = '0; e_addr = '0; e_idx = '0;
   endtask

   task automatic model_step(input logic v, input logic t, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic r, input logic f);
      btb_upd_t e;
      bit upd = v && t;
      e_we  = 1'b0;
      e_inv = 1'b0;
      if (m_phase == 0 && r && f) begin
         if (upd) m_drop++;
         mq.delete();
         m_phase = 1; e_inv = 1'b1; e_idx = 8'd0; m_next = 1;
      end else if (m_phase == 0) begin
         if (upd) begin
            if (COAL && mq.size() > 0 && mq[$].pc == pc) mq[$].target = tgt;
            else if (mq.size() < DEPTH) mq.push_back('{pc: pc, target: tgt});
            else m_drop++;
         end
         if (r && mq.size() > 0) begin
            e = mq.pop_front();
            e_we = 1'b1; e_pc = e.pc; e_addr = e.target;
         end
      end else begin
         if (upd) m_drop++;
         if (r && m_phase == 1) begin
            if (m_next == 256) m_phase = 2;
            else begin e_inv = 1'b1; e_idx = 8'(m_next); m_next++; end
         end else if (r) begin
            m_phase = 0;
         end
      end
      if (m_drop > 65535) m_drop = 65535;
   endtask

   task automatic compare_outputs();
      check("we", 64'(bus.btb_we_o), 64'(e_we));
      check("inv", 64'(bus.btb_inv_o), 64'(e_inv));
      check("busy", 64'(flush_busy_o), 64'(m_phase != 0));
      check("full", 64'(upd_full_o), 64'(mq.size() == DEPTH));
      check("drop", 64'(drop_cnt_o), 64'(m_drop));
      if (e_we) begin
         check("pc", 64'(bus.btb_pc_o), 64'(e_pc));
         check("addr", 64'(bus.btb_addr_o), 64'(e_addr));
      end
      if (e_inv) check("inv_idx", 64'(bus.btb_inv_idx_o), 64'(e_idx));
   endtask

   task automatic cycle(input logic v, input logic t, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic r, input logic f);
      bus.ex_valid_i  = v;
      bus.ex_taken_i  = t;
      bus.ex_pc_i     = pc;
      bus.ex_target_i = tgt;
      rdy             = r;
      flush_req_i     = f;
      @(posedge clk);
      model_step(v, t, pc, tgt, r, f);
      #1;
      compare_outputs();
   endtask

   task automatic idle_cycles(input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, r, 1'b0);
   endtask

   task automatic check_all_zero();
      check("rst_we", 64'(bus.btb_we_o), 64'd0);
      check("rst_inv", 64'(bus.btb_inv_o), 64'd0);
      check("rst_idx", 64'(bus.btb_inv_idx_o), 64'd0);
      check("rst_pc", 64'(bus.btb_pc_o), 64'd0);
      check("rst_addr", 64'(bus.btb_addr_o), 64'd0);
      check("rst_busy", 64'(flush_busy_o), 64'd0);
      check("rst_full", 64'(upd_full_o), 64'd0);
      check("rst_drop", 64'(drop_cnt_o), 64'd0);
   endtask

   initial begin
      int  k;
      bit  found;
      rst = 1'b1; rdy = 1'b0; flush_req_i = 1'b0;
      bus.ex_valid_i = 1'b0; bus.ex_taken_i = 1'b0;
      bus.ex_pc_i = '0; bus.ex_target_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      phase = "reset";
      check_all_zero();
      rst = 1'b0;

      phase = "single";
      idle_cycles(8, 1'b1);
      cycle(1'b1, 1'b1, 32'h1004, 32'h2000, 1'b1, 1'b0);
      check("single_we", 64'(bus.btb_we_o), 64'd1);
      idle_cycles(3, 1'b1);

      phase = "nottaken";
      cycle(1'b1, 1'b0, 32'h1100, 32'h2100, 1'b1, 1'b0);
      idle_cycles(2, 1'b1);

      phase = "stall_fill";
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'b1, 32'h4000 + 32'(i * 4), 32'h8000 + 32'(i * 16), 1'b0, 1'b0);
      check("fill_full", 64'(upd_full_o), 64'd1);
      check("fill_drop", 64'(drop_cnt_o), 64'd1);
      idle_cycles(6, 1'b1);

      phase = "flush_q3";
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, 32'h5000 + 32'(i * 4), 32'h9000, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      k = 0;
      for (int i = 1; i <= 300; i++) begin
         cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         if (!flush_busy_o) begin k = i; break; end
      end
      check("busy_len", 64'(k), 64'd257);
      idle_cycles(2, 1'b1);

      phase = "flush_drop";
      cycle(1'b1, 1'b1, 32'h6000, 32'h7000, 1'b1, 1'b1);
      idle_cycles(10, 1'b1);
      cycle(1'b1, 1'b1, 32'h6004, 32'h7004, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 32'h6008, 32'h7008, 1'b0, 1'b0);
      idle_cycles(260, 1'b1);

      phase = "coalesce";
      cycle(1'b1, 1'b1, 32'h1004, 32'h2000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h1004, 32'h3000, 1'b0, 1'b0);
      idle_cycles(4, 1'b1);

      phase = "rst_sweep";
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.btb_inv_o && bus.btb_inv_idx_o == 8'd100) begin found = 1'b1; break; end
         cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      check("reach_idx100", 64'(found), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_all_zero();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b1, 1'b0);
      idle_cycles(2, 1'b1);

      phase = "random";
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 7),
               32'h1000 + 32'($urandom_range(0, 3) * 4), $urandom,
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
